// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: AXI4-Lite slave register bank with RW/RO registers, byte strobes and access pulses
module axi_lite_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_NUM_REGS = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK = '0
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_i,
  output logic [C_NUM_REGS-1:0]                    wr_pulse_o,
  output logic [C_NUM_REGS-1:0]                    rd_pulse_o
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int ADW = C_S_AXI_ADDR_WIDTH;
  localparam int N = C_NUM_REGS;
  localparam int SW = DW / 8;
  localparam int SH = $clog2(SW);
  localparam int IW = $clog2(N);
  logic [N-1:0][DW-1:0] regs_q, regs_d;
  logic aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADW-1:0] awaddr_q, awaddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [N-1:0] wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;
  logic aw_hs, w_hs, ar_hs, commit, w_in, w_rw, r_in;
  logic [ADW-1:0] wa, widx, ridx;
  logic [DW-1:0] wd;
  logic [SW-1:0] ws;
  logic [IW-1:0] wi, ri;
  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};
  always_comb begin
    aw_hs = S_AXI_AWVALID & awready_q;
    w_hs = S_AXI_WVALID & wready_q;
    ar_hs = S_AXI_ARVALID & arready_q;
    wa = aw_full_q ? awaddr_q : S_AXI_AWADDR;
    wd = w_full_q ? wdata_q : S_AXI_WDATA;
    ws = w_full_q ? wstrb_q : S_AXI_WSTRB;
    commit = (aw_full_q | aw_hs) & (w_full_q | w_hs);
    widx = wa >> SH;
    w_in = widx < ADW'(N);
    wi = widx[IW-1:0];
    w_rw = w_in & ~C_RO_MASK[wi];
    ridx = S_AXI_ARADDR >> SH;
    r_in = ridx < ADW'(N);
    ri = ridx[IW-1:0];
    regs_d = regs_q;
    for (int b = 0; b < SW; b++)
      if (commit & w_rw & ws[b]) regs_d[wi][8*b +: 8] = wd[8*b +: 8];
    aw_full_d = commit ? 1'b0 : (aw_hs | aw_full_q);
    w_full_d = commit ? 1'b0 : (w_hs | w_full_q);
    awaddr_d = aw_hs ? S_AXI_AWADDR : awaddr_q;
    wdata_d = w_hs ? S_AXI_WDATA : wdata_q;
    wstrb_d = w_hs ? S_AXI_WSTRB : wstrb_q;
    bvalid_d = commit | (bvalid_q & ~S_AXI_BREADY);
    bresp_d = commit ? (w_in ? 2'b00 : 2'b10) : bresp_q;
    wr_pulse_d = (commit & w_rw) ? N'(1) << wi : '0;
    awready_d = ~aw_full_d & ~bvalid_d;
    wready_d = ~w_full_d & ~bvalid_d;
    rvalid_d = ar_hs | (rvalid_q & ~S_AXI_RREADY);
    arready_d = ~rvalid_d;
    rdata_d = ar_hs ? (r_in ? (C_RO_MASK[ri] ? regs_i[ri*DW +: DW] : regs_q[ri]) : '0) : rdata_q;
    rresp_d = ar_hs ? (r_in ? 2'b00 : 2'b10) : rresp_q;
    rd_pulse_d = (ar_hs & r_in) ? N'(1) << ri : '0;
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      regs_q <= '0;
      aw_full_q <= 1'b0;
      w_full_q <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q <= 2'b00;
      rdata_q <= '0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
    end else begin
      regs_q <= regs_d;
      aw_full_q <= aw_full_d;
      w_full_q <= w_full_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      awready_q <= awready_d;
      wready_q <= wready_d;
      arready_q <= arready_d;
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY = wready_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP = rresp_q;
  assign S_AXI_RDATA = rdata_q;
  assign regs_o = regs_q;
  assign wr_pulse_o = wr_pulse_q;
  assign rd_pulse_o = rd_pulse_q;
endmodule

// File: doc/axi_lite_regbank.md
AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank

Interface
REQ-001 Parameters (name, default, meaning):
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 or 64 allowed.
- C_S_AXI_ADDR_WIDTH, 8, byte-address width.
- C_NUM_REGS, 8, register count, 2..64.
- C_RO_MASK, all-zero (C_NUM_REGS bits), bit i=1 makes register i read-only and sourced from regs_i.
REQ-002 Ports (name, direction, width, meaning):
- S_AXI_ACLK, in, 1, sole clock.
- S_AXI_ARESET, in, 1, reset; synchronous, active-high.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, in/in/in/out, ADDR_W/3/1/1, write address channel; PROT ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY, in/in/in/out, DW/DW/8/1/1, write data channel.
- S_AXI_BRESP/BVALID/BREADY, out/out/in, 2/1/1, write response.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, in/in/in/out, ADDR_W/3/1/1, read address; PROT ignored.
- S_AXI_RDATA/RRESP/RVALID/RREADY, out/out/out/in, DW/2/1/1, read data.
- regs_o, out, C_NUM_REGS*DW, register i at slice [i*DW +: DW]; RO slices driven 0.
- regs_i, in, C_NUM_REGS*DW, read source for RO registers; RW slices ignored.
- wr_pulse_o, out, C_NUM_REGS, one-cycle strobe per committed write to an RW register.
- rd_pulse_o, out, C_NUM_REGS, one-cycle strobe per accepted in-range read.

Function
REQ-003 Register index = address >> log2(DW/8), over the full address; byte-offset bits ignored; index >= C_NUM_REGS is out-of-range.
REQ-004 AW and W channels accepted independently, in either order or the same cycle; each holds one captured beat.
REQ-005 AWREADY = not(AW captured) and not BVALID; WREADY = not(W captured) and not BVALID; both driven from registers only, with no combinational path from any VALID.
REQ-006 Commit occurs on the edge where the second of AW/W handshakes completes, or both complete together; capture flags clear on that edge.
REQ-007 On commit to an in-range RW register, each byte with WSTRB set is updated and other bytes are kept; new value appears on regs_o in the following cycle.
REQ-008 wr_pulse_o[i] is high for exactly the cycle after the commit edge, RW registers only, and fires even if WSTRB = 0.
REQ-009 A write to an RO register changes nothing, gives BRESP OKAY (2'b00) and no pulse; a write out-of-range changes nothing, gives BRESP SLVERR (2'b10) and no pulse.
REQ-010 BVALID rises the cycle after commit and holds until BREADY; it clears on the edge where BVALID and BREADY are both high. Only one write is outstanding.
REQ-011 ARREADY = not RVALID (registered).
REQ-012 On an AR handshake at edge k: RVALID=1 from cycle k+1; RDATA and RRESP are captured at k and held stable until the R handshake.
REQ-013 RDATA source: RW register gives the internal value; RO register gives the regs_i slice sampled at edge k; out-of-range gives 0 with RRESP SLVERR, otherwise OKAY.
REQ-014 rd_pulse_o[i] is high for exactly cycle k+1 of an in-range read, RO or RW.
REQ-015 Read and write commit to the same register on the same edge: the read returns the pre-write value.
REQ-016 Read and write channels operate concurrently and independently.
REQ-017 BRESP and RRESP never take the values EXOKAY or DECERR.

Reset
REQ-018 While S_AXI_ARESET is high at an edge: all RW registers = 0; AWREADY, WREADY, ARREADY = 0 during reset; BVALID, RVALID = 0; BRESP, RRESP, RDATA = 0; capture flags cleared; pulses = 0.
REQ-019 The cycle after reset deasserts, AWREADY, WREADY and ARREADY = 1.
REQ-020 Reset mid-transaction discards captured beats and pending responses; no register update occurs after reset.

Verification
Common configuration: DW=32, C_NUM_REGS=8, C_RO_MASK=8'h02.
REQ-021 AW(0x00) and W(0xDEADBEEF, strb 0xF) in the same cycle -> regs_o[0] = 0xDEADBEEF next cycle; wr_pulse_o=8'h01 for one cycle; BRESP=00; AWREADY low until B handshake.
REQ-022 W(0x000000AA, strb 0x1) three cycles before AW(0x0C), reg3 preset 0x11223344 -> reg3 = 0x112233AA; commit happens on the AW edge.
REQ-023 regs_i slice 1 = 0x5A5A0001, read 0x04 -> RDATA = 0x5A5A0001, RRESP=00, rd_pulse_o=8'h02; write 0x04 -> BRESP=00, no change, no pulse.
REQ-024 Read 0x40 (index 16) -> RDATA = 0, RRESP=10; write 0x40 -> BRESP=10, all registers unchanged.
REQ-025 RREADY held low 5 cycles -> RDATA/RVALID stable and ARREADY=0 throughout; BREADY low similarly blocks AWREADY/WREADY.
REQ-026 Reset asserted after AW captured and before W -> after release, a lone W does not commit; all registers = 0.
